// File: rtl/wb_reg_bank_if.sv
// Wishbone classic bus bundle between an interconnect master and the register bank.
// Signal names keep the slave-side _i/_o suffixes so they read the same inside the bank.
//   master modport: drives cyc/stb/adr/sel/we/dat_i, observes ack/err/rty/stall/dat_o
//   slave  modport: the reverse
interface wb_reg_bank_if #(
    parameter int unsigned ADR_W  = 2,
    parameter int unsigned DATA_W = 32
);
    logic                  wb_cyc_i;
    logic                  wb_stb_i;
    logic [ADR_W-1:0]      wb_adr_i;
    logic [DATA_W/8-1:0]   wb_sel_i;
    logic                  wb_we_i;
    logic [DATA_W-1:0]     wb_dat_i;
    logic                  wb_ack_o;
    logic                  wb_err_o;
    logic                  wb_rty_o;
    logic                  wb_stall_o;
    logic [DATA_W-1:0]     wb_dat_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_adr_i, wb_sel_i, wb_we_i, wb_dat_i,
        input  wb_ack_o, wb_err_o, wb_rty_o, wb_stall_o, wb_dat_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_adr_i, wb_sel_i, wb_we_i, wb_dat_i,
        output wb_ack_o, wb_err_o, wb_rty_o, wb_stall_o, wb_dat_o
    );
endinterface

// File: rtl/wb_reg_bank.sv
// Parametrised Wishbone classic slave register bank: NREGS registers of DATA_W bits,
// each read-write, read-only (sourced from regs_i) or write-pulse (self-clearing).
// One transaction in flight: IDLE (accept) -> EXEC (decode/update) -> RESP (ack or err).
// Ports:
//   clk_i, rst_n_i  rising-edge clock, synchronous active-low reset
//   wb              Wishbone slave bundle (wb_reg_bank_if.slave)
//   regs_o          register contents, slice i = register i (RO slices read 0,
//                   pulse slices carry written bytes only in the RESP cycle)
//   regs_i          read-only sources, slice i used when RO_MASK[i]=1
//   wr_strobe_o     one-cycle pulse per register written, aligned with the ack
module wb_reg_bank #(
    parameter int unsigned               NREGS      = 4,
    parameter int unsigned               DATA_W     = 32,
    parameter logic [NREGS-1:0]          RO_MASK    = '0,
    parameter logic [NREGS-1:0]          PULSE_MASK = '0,
    parameter logic [NREGS*DATA_W-1:0]   RST_VAL    = '0
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    wb_reg_bank_if.slave               wb,
    output logic [NREGS*DATA_W-1:0]    regs_o,
    input  logic [NREGS*DATA_W-1:0]    regs_i,
    output logic [NREGS-1:0]           wr_strobe_o
);

    localparam int unsigned ADR_W = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam int unsigned SEL_W = DATA_W / 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ADR_W-1:0]  adr_q,   adr_d;
    logic              we_q,    we_d;
    logic [SEL_W-1:0]  sel_q,   sel_d;
    logic [DATA_W-1:0] wdat_q,  wdat_d;
    logic              ack_q,   ack_d;
    logic              err_q,   err_d;
    logic [DATA_W-1:0] rdat_q,  rdat_d;
    logic [NREGS-1:0]  strobe_q, strobe_d;
    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];

    logic wb_en_c;

    assign wb_en_c       = wb.wb_cyc_i & wb.wb_stb_i;
    assign wb.wb_stall_o = wb_en_c & ~(ack_q | err_q);
    assign wb.wb_rty_o   = 1'b0;
    assign wb.wb_ack_o   = ack_q;
    assign wb.wb_err_o   = err_q;
    assign wb.wb_dat_o   = rdat_q;
    assign wr_strobe_o   = strobe_q;

    // Flatten register storage onto the fabric-facing vector
    always_comb begin
        regs_o = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            regs_o[i*DATA_W +: DATA_W] = regs_q[i];
        end
    end

    // Next-state, decode and register update
    always_comb begin
        state_d  = state_q;
        adr_d    = adr_q;
        we_d     = we_q;
        sel_d    = sel_q;
        wdat_d   = wdat_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        rdat_d   = '0;
        strobe_d = '0;
        regs_d   = regs_q;

        // Only RW registers hold state; pulse slices self-clear, RO slices stay 0
        for (int unsigned i = 0; i < NREGS; i++) begin
            if (RO_MASK[i] || PULSE_MASK[i]) begin
                regs_d[i] = '0;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (wb_en_c) begin
                    adr_d   = ADR_W'(wb.wb_adr_i);
                    we_d    = wb.wb_we_i;
                    sel_d   = SEL_W'(wb.wb_sel_i);
                    wdat_d  = DATA_W'(wb.wb_dat_i);
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_RESP;
                // Exact match per register; an address that hits nothing is an error
                for (int unsigned i = 0; i < NREGS; i++) begin
                    if (adr_q == ADR_W'(i)) begin
                        if (we_q) begin
                            if (!RO_MASK[i]) begin
                                ack_d       = 1'b1;
                                strobe_d[i] = 1'b1;
                                for (int unsigned j = 0; j < SEL_W; j++) begin
                                    if (sel_q[j]) begin
                                        regs_d[i][j*8 +: 8] = wdat_q[j*8 +: 8];
                                    end
                                end
                            end
                        end else begin
                            ack_d = 1'b1;
                            if (RO_MASK[i]) begin
                                rdat_d = regs_i[i*DATA_W +: DATA_W];
                            end else if (PULSE_MASK[i]) begin
                                rdat_d = '0;
                            end else begin
                                rdat_d = regs_q[i];
                            end
                        end
                    end
                end
                err_d = ~ack_d;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_IDLE;
            adr_q    <= '0;
            we_q     <= 1'b0;
            sel_q    <= '0;
            wdat_q   <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            rdat_q   <= '0;
            strobe_q <= '0;
            for (int unsigned i = 0; i < NREGS; i++) begin
                if (RO_MASK[i] || PULSE_MASK[i]) begin
                    regs_q[i] <= '0;
                end else begin
                    regs_q[i] <= RST_VAL[i*DATA_W +: DATA_W];
                end
            end
        end else begin
            state_q  <= state_d;
            adr_q    <= adr_d;
            we_q     <= we_d;
            sel_q    <= sel_d;
            wdat_q   <= wdat_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            rdat_q   <= rdat_d;
            strobe_q <= strobe_d;
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

endmodule

// File: tb/tb_wb_reg_bank.sv
// Directed bench for wb_reg_bank: a 4-register build (A) and a 5-register build (B)
// share one set of master signals; a scoreboard queue carries expected responses.
module tb_wb_reg_bank;

    typedef struct packed {
        logic        err;
        logic        rd;
        logic [31:0] rdat;
        logic [4:0]  strobe;
        logic [31:0] pulse;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cyc, stb, we, sel_b;
    logic [2:0]  adr;
    logic [3:0]  sel;
    logic [31:0] dat;

    logic [127:0] regs_a;
    logic [159:0] regs_b;
    logic [127:0] src_a;
    logic [159:0] src_b;
    logic [3:0]   strobe_a;
    logic [4:0]   strobe_b;

    logic        m_ack, m_err, m_stall;
    logic [31:0] m_dat;
    logic [4:0]  m_strobe;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc_n    = 0;
    exp_t sb[$];
    logic [31:0] mdl [2][5];

    wb_reg_bank_if #(.ADR_W(2), .DATA_W(32)) ifa ();
    wb_reg_bank_if #(.ADR_W(3), .DATA_W(32)) ifb ();

    wb_reg_bank #(
        .NREGS(4), .DATA_W(32), .RO_MASK(4'b0100), .PULSE_MASK(4'b1000),
        .RST_VAL({32'h0, 32'h0, 32'hDEADBEEF, 32'h0})
    ) dut_a (
        .clk_i(clk), .rst_n_i(rst_n), .wb(ifa.slave),
        .regs_o(regs_a), .regs_i(src_a), .wr_strobe_o(strobe_a)
    );

    wb_reg_bank #(
        .NREGS(5), .DATA_W(32), .RO_MASK(5'b00100), .PULSE_MASK(5'b01000),
        .RST_VAL({32'h0, 32'h0, 32'h0, 32'hDEADBEEF, 32'h0})
    ) dut_b (
        .clk_i(clk), .rst_n_i(rst_n), .wb(ifb.slave),
        .regs_o(regs_b), .regs_i(src_b), .wr_strobe_o(strobe_b)
    );

    assign ifa.wb_cyc_i = cyc & ~sel_b;
    assign ifa.wb_stb_i = stb & ~sel_b;
    assign ifa.wb_adr_i = adr[1:0];
    assign ifa.wb_sel_i = sel;
    assign ifa.wb_we_i  = we;
    assign ifa.wb_dat_i = dat;
    assign ifb.wb_cyc_i = cyc & sel_b;
    assign ifb.wb_stb_i = stb & sel_b;
    assign ifb.wb_adr_i = adr;
    assign ifb.wb_sel_i = sel;
    assign ifb.wb_we_i  = we;
    assign ifb.wb_dat_i = dat;

    assign m_ack    = sel_b ? ifb.wb_ack_o   : ifa.wb_ack_o;
    assign m_err    = sel_b ? ifb.wb_err_o   : ifa.wb_err_o;
    assign m_stall  = sel_b ? ifb.wb_stall_o : ifa.wb_stall_o;
    assign m_dat    = sel_b ? ifb.wb_dat_o   : ifa.wb_dat_o;
    assign m_strobe = sel_b ? strobe_b       : {1'b0, strobe_a};

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 5; i++) mdl[b][i] = 32'h0;
            mdl[b][1] = 32'hDEADBEEF;
        end
    endtask

    // Reference behaviour: reg2 read-only, reg3 write-pulse, reg4 only exists in B
    task automatic model(input bit b, input bit w, input logic [2:0] a,
                         input logic [3:0] s, input logic [31:0] d, output exp_t e);
        int n;
        logic [31:0] m;
        n = b ? 5 : 4;
        e = '0;
        e.rd = ~w;
        m = 32'h0;
        for (int j = 0; j < 4; j++) if (s[j]) m[j*8 +: 8] = 8'hFF;
        if (int'(a) >= n || (w && a == 3'd2)) begin
            e.err = 1'b1;
        end else if (w) begin
            e.strobe[a] = 1'b1;
            if (a == 3'd3) e.pulse = d & m;
            else mdl[b][a] = (mdl[b][a] & ~m) | (d & m);
        end else begin
            if (a == 3'd2)      e.rdat = 32'h12345678;
            else if (a == 3'd3) e.rdat = 32'h0;
            else                e.rdat = mdl[b][a];
        end
    endtask

    // One Wishbone classic transaction; returns in the IDLE cycle after the response
    task automatic txn(input bit b, input bit w, input logic [2:0] a,
                       input logic [3:0] s, input logic [31:0] d);
        exp_t e;
        exp_t got;
        int   lat;
        bit   seen;
        model(b, w, a, s, d, e);
        sb.push_back(e);
        sel_b = b; we = w; adr = a; sel = s; dat = d; cyc = 1'b1; stb = 1'b1;
        lat = 0; seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(negedge clk);
            lat++;
            if (m_ack || m_err) seen = 1'b1;
            else chk("stall_wait", {159'b0, m_stall}, 160'd1);
        end
        chk("resp_seen", {159'b0, seen}, 160'd1);
        got = sb.pop_front();
        if (seen) begin
            chk("latency", 160'(lat), 160'd2);
            chk("ack", {159'b0, m_ack}, {159'b0, ~got.err});
            chk("err", {159'b0, m_err}, {159'b0, got.err});
            chk("stall_resp", {159'b0, m_stall}, 160'd0);
            chk("dat", {128'b0, m_dat}, {128'b0, (got.rd && !got.err) ? got.rdat : 32'h0});
            chk("strobe", {155'b0, m_strobe}, {155'b0, got.strobe});
            if (!b) begin
                chk("regs_resp", {32'b0, regs_a},
                    {32'b0, got.pulse, 32'h0, mdl[0][1], mdl[0][0]});
            end
        end
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        chk("resp_one_cycle", {158'b0, m_ack, m_err}, 160'd0);
        chk("dat_idle", {128'b0, m_dat}, 160'd0);
        chk("strobe_idle", {155'b0, m_strobe}, 160'd0);
        if (!b) chk("pulse_clear", {128'b0, regs_a[127:96]}, 160'd0);
    endtask

    initial begin
        int t0, t1, t2;
        src_a = {32'h0, 32'h12345678, 64'h0};
        src_b = {64'h0, 32'h12345678, 64'h0};
        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel_b = 1'b0;
        adr = 3'd0; sel = 4'h0; dat = 32'h0;
        reset_model();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        chk("rst_ack_err", {158'b0, ifa.wb_ack_o, ifa.wb_err_o}, 160'd0);
        chk("rst_dat", {128'b0, ifa.wb_dat_o}, 160'd0);
        chk("rst_strobe", {156'b0, strobe_a}, 160'd0);
        chk("rst_regs", {32'b0, regs_a}, {32'b0, 32'h0, 32'h0, 32'hDEADBEEF, 32'h0});
        chk("rst_rty", {159'b0, ifa.wb_rty_o}, 160'd0);

        // 1: read all registers after reset
        for (int i = 0; i < 4; i++) txn(1'b0, 1'b0, 3'(i), 4'hF, 32'h0);

        // 2: full write then single-lane overwrite
        txn(1'b0, 1'b1, 3'd0, 4'hF, 32'hA5A5A5A5);
        txn(1'b0, 1'b1, 3'd0, 4'b0001, 32'h000000FF);
        chk("reg0_merge", {128'b0, regs_a[31:0]}, {128'b0, 32'hA5A5A5FF});
        txn(1'b0, 1'b1, 3'd1, 4'b0000, 32'hFFFFFFFF);

        // 3: write to read-only register, out-of-range address on the 5-register build
        txn(1'b0, 1'b1, 3'd2, 4'hF, 32'hFFFFFFFF);
        txn(1'b1, 1'b0, 3'd5, 4'hF, 32'h0);
        txn(1'b1, 1'b1, 3'd4, 4'b0110, 32'h00CAFE00);
        txn(1'b1, 1'b0, 3'd4, 4'hF, 32'h0);
        txn(1'b1, 1'b1, 3'd7, 4'hF, 32'h1);

        // 4: pulse register write and read-back
        txn(1'b0, 1'b1, 3'd3, 4'hF, 32'h00000003);
        txn(1'b0, 1'b1, 3'd3, 4'b1010, 32'h11223344);
        txn(1'b0, 1'b0, 3'd3, 4'hF, 32'h0);

        // 5: reset while a write to reg1 is in EXEC
        sel_b = 1'b0; we = 1'b1; adr = 3'd1; sel = 4'hF; dat = 32'h11111111;
        cyc = 1'b1; stb = 1'b1;
        @(negedge clk);
        chk("pre_rst_no_resp", {158'b0, m_ack, m_err}, 160'd0);
        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        reset_model();
        chk("rst_mid_resp", {158'b0, m_ack, m_err}, 160'd0);
        chk("rst_mid_reg1", {128'b0, regs_a[63:32]}, {128'b0, 32'hDEADBEEF});
        chk("rst_mid_strobe", {155'b0, m_strobe}, 160'd0);
        @(negedge clk);
        chk("rst_mid_dropped", {158'b0, m_ack, m_err}, 160'd0);
        txn(1'b0, 1'b0, 3'd1, 4'hF, 32'h0);

        // 6: back-to-back writes, reasserting the cycle after each ack
        txn(1'b0, 1'b1, 3'd0, 4'hF, 32'h01020304);
        t0 = cyc_n;
        txn(1'b0, 1'b1, 3'd1, 4'b1100, 32'h55660000);
        t1 = cyc_n;
        txn(1'b0, 1'b1, 3'd0, 4'b0010, 32'h0000AB00);
        t2 = cyc_n;
        chk("spacing_1", 160'(t1 - t0), 160'd3);
        chk("spacing_2", 160'(t2 - t1), 160'd3);
        chk("final_regs", {32'b0, regs_a},
            {32'b0, 32'h0, 32'h0, 32'h5566BEEF, 32'h0102AB04});
        chk("sb_empty", 160'(sb.size()), 160'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
